// File: rtl/game_pkg.sv
// Shared types and default 100 MHz timing for the game front end.
// Button debouncer state encoding lives here so the game FSM and checkers can decode it.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WQ        = 3'd1,
    PRESS     = 3'd2,
    HOLD      = 3'd3,
    RPT_PULSE = 3'd4,
    RPT_WAIT  = 3'd5,
    WR        = 3'd6
  } btn_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_HOLD_CYCLES     = 50_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 10_000_000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces one push-button into a level, a press strobe, auto-repeat strobes
// and a continuous-repeat enable. All outputs decode from the registered state.
module button_debouncer
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pb,
  output logic       db_level,
  output logic       scen,
  output logic       mcen,
  output logic       ccen,
  output btn_state_t dbg_state
);

  localparam int unsigned MAX_CYCLES = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam int          CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);

  logic             pb_s;
  btn_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_inc;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pb),
    .q     (pb_s)
  );

  // The counter restarts on every state change, so each terminal compare is an equality.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else if (cnt_inc)        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    cnt_inc    = 1'b0;
    unique case (state)
      IDLE: if (pb_s) state_next = IDLE == IDLE ? WQ : IDLE;
      WQ: begin
        if (!pb_s)              state_next = IDLE;
        else if (cnt == DEB_TC) state_next = PRESS;
        else                    cnt_inc    = 1'b1;
      end
      PRESS:     state_next = HOLD;
      // Release is checked before the terminal count so it wins a collision.
      HOLD: begin
        if (!pb_s)               state_next = WR;
        else if (cnt == HOLD_TC) state_next = RPT_PULSE;
        else                     cnt_inc    = 1'b1;
      end
      RPT_PULSE: state_next = RPT_WAIT;
      RPT_WAIT: begin
        if (!pb_s)              state_next = WR;
        else if (cnt == REP_TC) state_next = RPT_PULSE;
        else                    cnt_inc    = 1'b1;
      end
      // A bounce back high returns to HOLD and restarts the hold timer, with no new press.
      WR: begin
        if (pb_s)               state_next = HOLD;
        else if (cnt == DEB_TC) state_next = IDLE;
        else                    cnt_inc    = 1'b1;
      end
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    db_level = 1'b0;
    scen     = 1'b0;
    mcen     = 1'b0;
    ccen     = 1'b0;
    unique case (state)
      PRESS: begin
        db_level = 1'b1;
        scen     = 1'b1;
        mcen     = 1'b1;
      end
      HOLD:      db_level = 1'b1;
      RPT_PULSE: begin
        db_level = 1'b1;
        mcen     = 1'b1;
        ccen     = 1'b1;
      end
      RPT_WAIT: begin
        db_level = 1'b1;
        ccen     = 1'b1;
      end
      WR:        db_level = 1'b1;
      default:   ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions one raw, bouncing push-button (BtnC or BtnD) into clean, clock-synchronous control strobes for the game FSM. That FSM's START/PLAY transitions consume `scen`.
- Sits directly upstream of the game/render block; the top level instantiates it once per button.
- Provides three outputs:
  - a debounced level,
  - a single-cycle press strobe,
  - auto-repeat strobes while the button is held.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a press or release (10 ms at 100 MHz); must be >= 1.
- HOLD_CYCLES, 50_000_000: held cycles after the press strobe before auto-repeat starts; must be >= 1.
- REPEAT_CYCLES, 10_000_000: cycles between auto-repeat strobes; must be >= 1.
- CNT_W, $clog2(max of the three above)+1: width of the shared counter; derived, not overridden.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- pb  in  1  raw button, asynchronous to clk, active-high.
- db_level  out  1  debounced button level.
- scen  out  1  single-clock enable: exactly one cycle per accepted press.
- mcen  out  1  multi-clock enable: one cycle at press, then one cycle per repeat period while held.
- ccen  out  1  continuous enable: high from the start of auto-repeat until release is accepted.

Behaviour:
- Synchronizer: pb passes through two flops to give pb_s. The FSM uses only pb_s.
- Counter: a single CNT_W-bit counter shared by all states. It clears on every state change.
- Reset (async, any time, including mid-debounce or mid-repeat):
  - state = IDLE, counter = 0, both sync flops = 0.
  - db_level = scen = mcen = ccen = 0.
- Outputs are Moore: decoded from the registered state only, with no combinational path from pb.
- States and transitions:
  - IDLE: outputs all 0. pb_s=1 -> WQ.
  - WQ (press qualify): outputs all 0. pb_s=0 -> IDLE. pb_s=1 and count==DEBOUNCE_CYCLES-1 -> PRESS. Otherwise count++.
  - PRESS: lasts one cycle, unconditionally -> HOLD. db_level=1, scen=1, mcen=1.
  - HOLD: db_level=1. pb_s=0 -> WR. count==HOLD_CYCLES-1 -> RPT_PULSE. Otherwise count++.
  - RPT_PULSE: lasts one cycle, unconditionally -> RPT_WAIT. db_level=1, mcen=1, ccen=1.
  - RPT_WAIT: db_level=1, ccen=1. pb_s=0 -> WR. count==REPEAT_CYCLES-1 -> RPT_PULSE. Otherwise count++.
  - WR (release qualify): db_level=1, ccen=0, no strobes. pb_s=1 -> HOLD with the counter cleared, so a bounce restarts the hold timer and does not produce a new scen. pb_s=0 and count==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise count++.
- Latency:
  - Raw pb rise to scen: 2 sync edges + 1 edge into WQ + DEBOUNCE_CYCLES edges. scen is high during cycle DEBOUNCE_CYCLES+3 after pb is first sampled.
  - Press strobe to first repeat strobe: HOLD_CYCLES+1 cycles.
  - Between repeat strobes: REPEAT_CYCLES+1 cycles.
- Glitch rule: a pb pulse shorter than DEBOUNCE_CYCLES synchronized cycles produces no output.
- Strobe rules:
  - scen fires at most once between two accepted releases.
  - mcen is never high on two consecutive cycles.
- Counter never wraps: its width covers the largest terminal count, and every compare is equality on a cleared counter.
- Simultaneous events: the pb_s=0 check has priority over terminal count in HOLD and RPT_WAIT, so release wins over a repeat.

Decomposition:
- Shared package `game_pkg`:
  - `btn_state_t` enum {IDLE, WQ, PRESS, HOLD, RPT_PULSE, RPT_WAIT, WR};
  - default timing constants at 100 MHz.
- Sub-module `sync_2ff` (1-bit two-flop synchronizer, async active-high reset to 0). Reusable for any async input.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3):
- Clean press: pb 0->1 held 10 cycles -> scen and mcen high for exactly 1 cycle, 7 edges after the rise; db_level high from that cycle; no ccen.
- Bounce reject: pb pulses high 3 cycles, low 2, high 2, then low -> db_level, scen, mcen and ccen stay 0 throughout.
- Auto-repeat: hold pb 40 cycles -> one scen; mcen at press, again 9 cycles later, then every 4 cycles; ccen high from the first repeat until release is qualified.
- Release bounce: after repeat starts, pb low 2 cycles, high 1, then low -> FSM returns to HOLD with no second scen; db_level stays 1 until 4 stable low cycles; then IDLE with all outputs 0.
- Async reset mid-RPT_WAIT: assert reset between clock edges -> all outputs 0 immediately (before the next edge); after deassert with pb held high, a fresh scen comes 7 edges later.
- Release/repeat collision: pb_s falls on the same cycle the RPT_WAIT count reaches 2 -> next state WR, no mcen pulse.
